// File: rtl/fft16_frame_scheduler.sv
// Time-shares one 16-point FFT core among N_CH frame sources: round-robin grant,
// a contiguous 16-sample feed burst, then tagged collection of the core's 16 bins.
module fft16_frame_scheduler #(
  parameter int N_CH       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 18,
  parameter int N_POINT    = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_i,
  input  logic [N_CH-1:0]              req_i,
  output logic [N_CH-1:0]              gnt_o,
  input  logic [N_CH*DATA_WIDTH-1:0]   ch_real_i,
  input  logic [N_CH*DATA_WIDTH-1:0]   ch_imag_i,
  output logic                         core_valid_o,
  output logic [DATA_WIDTH-1:0]        core_real_o,
  output logic [DATA_WIDTH-1:0]        core_imag_o,
  input  logic                         core_valid_i,
  input  logic [OUT_WIDTH-1:0]         core_real_i,
  input  logic [OUT_WIDTH-1:0]         core_imag_i,
  output logic                         m_valid_o,
  output logic [OUT_WIDTH-1:0]         m_real_o,
  output logic [OUT_WIDTH-1:0]         m_imag_o,
  output logic [CH_W-1:0]              m_ch_o,
  output logic [3:0]                   m_index_o,
  output logic                         m_last_o,
  output logic                         busy_o,
  output logic                         err_timeout_o,
  output logic [1:0]                   dbg_state_o
);

  // Valid-only streams, no backpressure: core_valid_o and m_valid_o qualify
  // their data for exactly the cycles they are high; the source and the core
  // must accept/deliver every qualified beat without stalls.
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_GAP} state_t;

  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]      LAST_IDX = 4'(N_POINT - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]   NCH_W    = (CH_W + 1)'(N_CH);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state_q;
  logic [CH_W-1:0]  sel_q, rr_ptr_q;
  logic [3:0]       feed_cnt_q, out_cnt_q;
  logic [TO_W-1:0]  wait_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic [N_CH-1:0]       req_rot;
  logic [CH_W:0]         pick_sum;
  logic [CH_W-1:0]       pick;
  logic [DATA_WIDTH-1:0] smp_re, smp_im;

  // Rotate so bit 0 is the rr pointer; the lowest set bit is the winner.
  assign req_rot = N_CH'({req_i, req_i} >> rr_ptr_q);

  always_comb begin
    pick_sum = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_sum = (CH_W + 1)'(i);
    end
    pick_sum = pick_sum + {1'b0, rr_ptr_q};
    if (pick_sum >= NCH_W) pick_sum = pick_sum - NCH_W;
  end

  assign pick = pick_sum[CH_W-1:0];

  always_comb begin
    smp_re = '0;
    smp_im = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == CH_W'(k)) begin
        smp_re = ch_real_i[k*DATA_WIDTH +: DATA_WIDTH];
        smp_im = ch_imag_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      feed_cnt_q    <= '0;
      out_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      gnt_o         <= '0;
      core_valid_o  <= 1'b0;
      core_real_o   <= '0;
      core_imag_o   <= '0;
      m_valid_o     <= 1'b0;
      m_real_o      <= '0;
      m_imag_o      <= '0;
      m_ch_o        <= '0;
      m_index_o     <= '0;
      m_last_o      <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      gnt_o         <= '0;
      core_valid_o  <= 1'b0;
      m_valid_o     <= 1'b0;
      m_last_o      <= 1'b0;
      err_timeout_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            gnt_o      <= N_CH'(1) << pick;
            sel_q      <= pick;
            rr_ptr_q   <= (pick == LAST_CH) ? '0 : pick + 1'b1;
            feed_cnt_q <= '0;
            state_q    <= S_FEED;
          end
        end
        S_FEED: begin
          // The grant cycle itself carries no sample; sample 0 arrives the cycle after.
          if (!(|gnt_o)) begin
            core_valid_o <= 1'b1;
            core_real_o  <= smp_re;
            core_imag_o  <= smp_im;
            feed_cnt_q   <= feed_cnt_q + 1'b1;
            if (feed_cnt_q == LAST_IDX) begin
              out_cnt_q  <= '0;
              wait_cnt_q <= '0;
              state_q    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (core_valid_i) begin
            m_valid_o <= 1'b1;
            m_real_o  <= core_real_i;
            m_imag_o  <= core_imag_i;
            m_ch_o    <= sel_q;
            m_index_o <= out_cnt_q;
            m_last_o  <= (out_cnt_q == LAST_IDX);
            out_cnt_q <= out_cnt_q + 1'b1;
            if (out_cnt_q == LAST_IDX) begin
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end
          end else if (out_cnt_q == '0) begin
            // Only the wait for the first bin is timed; gaps mid-burst are legal.
            if (wait_cnt_q == TO_LAST) begin
              err_timeout_o <= 1'b1;
              gap_cnt_q     <= '0;
              state_q       <= S_GAP;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_q <= S_IDLE;
          else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_frame_scheduler.sv
// Bench for fft16_frame_scheduler: random frames from two sources, a DFT-based
// core stand-in, and a scoreboard for both the core feed and the tagged results.
module tb_fft16_frame_scheduler;
  localparam int N_CH = 2;
  localparam int DW   = 8;
  localparam int OW   = 18;
  localparam int GAPC = 2;
  localparam int TMO  = 64;
  localparam int CH_W = 1;
  localparam int EW   = 2*OW + CH_W + 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH-1:0]      req, gnt;
  logic [N_CH*DW-1:0]   ch_real, ch_imag;
  logic                 core_valid_o, core_valid_i;
  logic [DW-1:0]        core_real_o, core_imag_o;
  logic [OW-1:0]        core_real_i, core_imag_i;
  logic                 m_valid, m_last, busy, err_to;
  logic [OW-1:0]        m_real, m_imag;
  logic [CH_W-1:0]      m_ch;
  logic [3:0]           m_index;
  logic [1:0]           dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [2*DW-1:0] feed_q[$];
  logic [EW-1:0]   exp_q[$];
  int rr_model    = 0;
  bit core_silent = 1'b0;
  int stray_go    = 0;

  always #5 clk = ~clk;

  fft16_frame_scheduler #(.N_CH(N_CH), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .N_POINT(16),
                          .GAP_CYCLES(GAPC), .TIMEOUT(TMO)) dut (
    .sys_clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
    .ch_real_i(ch_real), .ch_imag_i(ch_imag),
    .core_valid_o(core_valid_o), .core_real_o(core_real_o), .core_imag_o(core_imag_o),
    .core_valid_i(core_valid_i), .core_real_i(core_real_i), .core_imag_i(core_imag_i),
    .m_valid_o(m_valid), .m_real_o(m_real), .m_imag_o(m_imag), .m_ch_o(m_ch),
    .m_index_o(m_index), .m_last_o(m_last), .busy_o(busy), .err_timeout_o(err_to),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Direct 16-point DFT, X[k] = sum x[n] e^{-j 2 pi n k / 16}, rounded to integer.
  function automatic int dft_part(input int xr[16], input int xi[16], input int k, input bit im);
    real acc, ang;
    acc = 0.0;
    for (int n = 0; n < 16; n++) begin
      ang = 2.0 * 3.14159265358979 * real'((n * k) % 16) / 16.0;
      if (!im) acc = acc + real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
      else     acc = acc + real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
    end
    return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(-acc + 0.5);
  endfunction

  // Core stand-in: gathers 16 fed samples, answers with their DFT after a short
  // latency and with random holes; can also stay silent or emit stray beats.
  initial begin
    int ibuf_r[16], ibuf_i[16], obuf_r[16], obuf_i[16];
    int icnt, pend, dly, stray_done;
    icnt = 0; pend = 0; dly = 0; stray_done = 0;
    core_valid_i = 1'b0; core_real_i = '0; core_imag_i = '0;
    forever begin
      @(negedge clk);
      core_valid_i = 1'b0;
      if (rst) begin
        icnt = 0;
        pend = 0;
      end else begin
        if (core_valid_o) begin
          ibuf_r[icnt] = int'($signed(core_real_o));
          ibuf_i[icnt] = int'($signed(core_imag_o));
          icnt++;
          if (icnt == 16) begin
            icnt = 0;
            if (!core_silent) begin
              for (int k = 0; k < 16; k++) begin
                obuf_r[k] = dft_part(ibuf_r, ibuf_i, k, 1'b0);
                obuf_i[k] = dft_part(ibuf_r, ibuf_i, k, 1'b1);
              end
              pend = 16;
              dly  = $urandom_range(1, 6);
            end
          end
        end
        if (pend > 0) begin
          if (dly > 0) dly--;
          else if ($urandom_range(0, 3) != 0) begin
            core_valid_i = 1'b1;
            core_real_i  = OW'(obuf_r[16-pend]);
            core_imag_i  = OW'(obuf_i[16-pend]);
            pend--;
          end
        end else if (stray_done < stray_go) begin
          core_valid_i = 1'b1;
          core_real_i  = OW'($urandom);
          core_imag_i  = OW'($urandom);
          stray_done++;
        end
      end
    end
  end

  // Monitor: every beat on either stream must match the head of its queue.
  initial begin
    logic [2*DW-1:0] fe;
    logic [EW-1:0]   oe;
    int  low_run;
    bit  prev_v, seen_burst;
    low_run = 0; prev_v = 1'b0; seen_burst = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && core_valid_o) begin
        if (!prev_v && seen_burst) check("feed_gap_ok", 64'(low_run >= GAPC), 64'(1));
        seen_burst = 1'b1;
        if (feed_q.size() == 0) check("feed_unexpected", {core_real_o, core_imag_o}, 64'hdead);
        else begin
          fe = feed_q.pop_front();
          check("feed_sample", {core_real_o, core_imag_o}, fe);
        end
      end
      low_run = core_valid_o ? 0 : low_run + 1;
      prev_v  = core_valid_o;
      if (!rst && m_valid) begin
        if (exp_q.size() == 0) check("m_unexpected", {m_real, m_imag, m_ch, m_index, m_last}, 64'hdead);
        else begin
          oe = exp_q.pop_front();
          check("m_beat", {m_real, m_imag, m_ch, m_index, m_last}, oe);
        end
      end
    end
  end

  task automatic drive_junk();
    ch_real = N_CH*DW'($urandom);
    ch_imag = N_CH*DW'($urandom);
  endtask

  // kind: 0 random, 1 ramp real, 2 impulse. abort_at >= 0 fires reset at that sample.
  task automatic run_frame(input logic [N_CH-1:0] mask, input int kind, input bit silent,
                           input int abort_at);
    int exp_ch, waited, m, c;
    int xr[16], xi[16];
    exp_ch = -1;
    m = int'(mask);
    for (int i = 0; i < N_CH; i++) begin
      c = (rr_model + i) % N_CH;
      if (exp_ch < 0 && ((m >> c) & 1) == 1) exp_ch = c;
    end
    core_silent = silent;
    req = mask;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt === '0 && waited < 400);
    if (gnt === '0) begin
      check("grant_timeout", 64'(waited), 64'(0));
      req = '0;
      return;
    end
    check("gnt_onehot", 64'(gnt), 64'(N_CH'(1) << exp_ch));
    rr_model = (exp_ch + 1) % N_CH;
    for (int n = 0; n < 16; n++) begin
      case (kind)
        1:       begin xr[n] = n; xi[n] = 0; end
        2:       begin xr[n] = (n == 0) ? 1 : 0; xi[n] = 0; end
        default: begin xr[n] = int'($urandom_range(0, 255)) - 128; xi[n] = int'($urandom_range(0, 255)) - 128; end
      endcase
      feed_q.push_back({DW'(xr[n]), DW'(xi[n])});
    end
    if (!silent) begin
      for (int k = 0; k < 16; k++)
        exp_q.push_back({OW'(dft_part(xr, xi, k, 1'b0)), OW'(dft_part(xr, xi, k, 1'b1)),
                         CH_W'(exp_ch), 4'(k), (k == 15)});
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n == 0) check("gnt_single_cycle", 64'(gnt), 64'(0));
      drive_junk();
      ch_real[exp_ch*DW +: DW] = DW'(xr[n]);
      ch_imag[exp_ch*DW +: DW] = DW'(xi[n]);
      if (n == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_core_valid", 64'(core_valid_o), 64'(0));
        check("rst_core_data", {core_real_o, core_imag_o}, 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_busy_state", {busy, dbg_state, gnt}, 64'(0));
        feed_q.delete();
        exp_q.delete();
        rr_model = 0;
        req = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    drive_junk();
    req = '0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || feed_q.size() != 0 || busy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("idle_timeout", 64'(w), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, mcount;
    rst = 1'b1;
    req = '0;
    ch_real = '0;
    ch_imag = '0;
    repeat (3) @(negedge clk);
    check("reset_gnt", 64'(gnt), 64'(0));
    check("reset_core_valid", 64'(core_valid_o), 64'(0));
    check("reset_m_outputs", {m_valid, m_real, m_imag, m_ch, m_index, m_last}, 64'(0));
    check("reset_busy_err", {busy, err_to, dbg_state}, 64'(0));
    #2 rst = 1'b0;

    run_frame(2'b01, 1, 1'b0, -1);
    wait_idle();
    run_frame(2'b10, 2, 1'b0, -1);
    wait_idle();
    for (int i = 0; i < 3; i++) run_frame(2'b11, 0, 1'b0, -1);
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      run_frame(N_CH'($urandom_range(1, (1 << N_CH) - 1)), 0, 1'b0, -1);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    stray_go = stray_go + 4;
    mcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) mcount++;
    end
    check("stray_no_m_valid", 64'(mcount), 64'(0));

    run_frame(2'b01, 0, 1'b1, -1);
    cyc = 17;
    while (!err_to && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycle", 64'(cyc), 64'(17 + TMO));
    @(negedge clk);
    check("timeout_pulse_busy", {err_to, busy}, 64'b01);
    @(negedge clk);
    check("timeout_idle", 64'(busy), 64'(0));
    check("timeout_feed_drained", 64'(feed_q.size()), 64'(0));
    core_silent = 1'b0;

    run_frame(2'b01, 0, 1'b0, -1);
    wait_idle();
    run_frame(2'b01, 0, 1'b0, 6);
    run_frame(2'b11, 0, 1'b0, -1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
